// File: rtl/mem_bus_decoder_if.sv
// CPU-side and shared-slave-side signals of the memory bus decoder.
// The decoder uses the slave modport; the CPU/slave models use master.
interface mem_bus_decoder_if;
   logic        cpu_mem_valid;
   logic [31:0] cpu_mem_addr;
   logic        cpu_mem_ready;
   logic [31:0] cpu_mem_rdata;
   logic        mem_enable;
   logic        io_enable;
   logic        bus_ready;
   logic [31:0] bus_rdata;
   logic        bus_error;
   logic [31:0] err_addr;
   logic        err_clear;

   modport slave (
      input  cpu_mem_valid, cpu_mem_addr, bus_ready, bus_rdata, err_clear,
      output cpu_mem_ready, cpu_mem_rdata, mem_enable, io_enable, bus_error, err_addr
   );

   modport master (
      output cpu_mem_valid, cpu_mem_addr, bus_ready, bus_rdata, err_clear,
      input  cpu_mem_ready, cpu_mem_rdata, mem_enable, io_enable, bus_error, err_addr
   );
endinterface

// File: rtl/mem_bus_decoder.sv
// Address decoder between the CPU memory port and the shared slave bus, with
// error termination of unmapped or hung accesses.
//
// state  | meaning
// IDLE   | no access in flight, waiting for cpu_mem_valid
// ACTIVE | slave selected, forwarding bus_ready/bus_rdata, timeout running
// ERR    | one-cycle error response (ERR_DATA) to the CPU
// DONE   | one dead cycle so the CPU can drop valid before re-decode
module mem_bus_decoder #(
   parameter logic [31:0] MEM_BASE = 32'h0000_0000,
   parameter logic [31:0] MEM_SIZE = 32'h0000_8000,
   parameter logic [31:0] IO_BASE  = 32'hFFFF_0000,
   parameter logic [31:0] IO_SIZE  = 32'h0000_1000,
   parameter int unsigned TIMEOUT  = 16,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input logic               clk,
   input logic               reset,
   mem_bus_decoder_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_ERR    = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam logic [7:0] CNT_TC = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        mem_en_q, mem_en_d;
   logic        io_en_q, io_en_d;
   logic        err_q, err_d;
   logic [31:0] err_addr_q, err_addr_d;
   logic        ready;
   logic [31:0] rdata;
   logic        hit_mem, hit_io;

   // Unsigned offset compare: addresses below BASE wrap to large values and miss.
   assign hit_mem = (bus.cpu_mem_addr - MEM_BASE) < MEM_SIZE;
   assign hit_io  = (bus.cpu_mem_addr - IO_BASE) < IO_SIZE;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         mem_en_q   <= 1'b0;
         io_en_q    <= 1'b0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mem_en_q   <= mem_en_d;
         io_en_q    <= io_en_d;
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mem_en_d   = mem_en_q;
      io_en_d    = io_en_q;
      err_d      = err_q;
      err_addr_d = err_addr_q;
      ready      = 1'b0;
      rdata      = '0;

      // Clear first so an error entry on the same edge overrides it.
      if (bus.err_clear) err_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            mem_en_d = 1'b0;
            io_en_d  = 1'b0;
            if (bus.cpu_mem_valid) begin
               if (hit_mem) begin
                  mem_en_d = 1'b1;
                  cnt_d    = '0;
                  state_d  = S_ACTIVE;
               end else if (hit_io) begin
                  io_en_d  = 1'b1;
                  cnt_d    = '0;
                  state_d  = S_ACTIVE;
               end else begin
                  err_d      = 1'b1;
                  err_addr_d = bus.cpu_mem_addr;
                  state_d    = S_ERR;
               end
            end
         end
         S_ACTIVE: begin
            ready = bus.bus_ready;
            rdata = bus.bus_rdata;
            if (bus.bus_ready) begin
               mem_en_d = 1'b0;
               io_en_d  = 1'b0;
               state_d  = S_DONE;
            end else if (!bus.cpu_mem_valid) begin
               mem_en_d = 1'b0;
               io_en_d  = 1'b0;
               state_d  = S_IDLE;
            end else if (cnt_q == CNT_TC) begin
               mem_en_d   = 1'b0;
               io_en_d    = 1'b0;
               err_d      = 1'b1;
               err_addr_d = bus.cpu_mem_addr;
               state_d    = S_ERR;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_ERR: begin
            ready   = 1'b1;
            rdata   = ERR_DATA;
            state_d = S_DONE;
         end
         S_DONE: begin
            mem_en_d = 1'b0;
            io_en_d  = 1'b0;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.cpu_mem_ready = ready;
   assign bus.cpu_mem_rdata = rdata;
   assign bus.mem_enable    = mem_en_q;
   assign bus.io_enable     = io_en_q;
   assign bus.bus_error     = err_q;
   assign bus.err_addr      = err_addr_q;

endmodule

// File: tb/tb_mem_bus_decoder.sv
// Directed bench for mem_bus_decoder: stimulus changes on negedges, a monitor
// pops expected read data from a scoreboard whenever the CPU sees ready.
module tb_mem_bus_decoder;

   localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;
   localparam int K_RAM = 0;
   localparam int K_IO  = 1;
   localparam int K_UNM = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_bus_decoder_if bus_if ();

   mem_bus_decoder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   int          total  = 0;
   int          passed = 0;
   logic [31:0] sb_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Response monitor, sampled 2 time units before each posedge.
   always begin
      @(negedge clk);
      #3;
      if (bus_if.cpu_mem_ready === 1'b1) begin
         total++;
         assert (sb_q.size() != 0) passed++;
         else $error("FAIL sb_unexpected_ready observed=ready expected=no_pending_access");
         if (sb_q.size() != 0) check("sb_rdata", bus_if.cpu_mem_rdata, sb_q.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=no_finish expected=finish");
      $fatal(1, "watchdog expired");
   end

   // One complete access; RAM/IO slaves answer in the first ACTIVE cycle.
   task automatic access(input logic [31:0] addr, input int kind, input logic [31:0] data);
      @(negedge clk);
      bus_if.cpu_mem_valid = 1'b1;
      bus_if.cpu_mem_addr  = addr;
      sb_q.push_back((kind == K_UNM) ? ERR_WORD : data);
      @(negedge clk);
      check("acc_mem_en", 32'(bus_if.mem_enable), 32'(kind == K_RAM));
      check("acc_io_en", 32'(bus_if.io_enable), 32'(kind == K_IO));
      if (kind != K_UNM) begin
         bus_if.bus_ready = 1'b1;
         bus_if.bus_rdata = data;
      end
      @(negedge clk);
      bus_if.bus_ready     = 1'b0;
      bus_if.bus_rdata     = '0;
      bus_if.cpu_mem_valid = 1'b0;
      check("acc_en_done", 32'({bus_if.mem_enable, bus_if.io_enable}), 32'd0);
      check("acc_drained", 32'(sb_q.size()), 32'd0);
      if (kind == K_UNM) begin
         check("acc_bus_error", 32'(bus_if.bus_error), 32'd1);
         check("acc_err_addr", bus_if.err_addr, addr);
         bus_if.err_clear = 1'b1;
         @(negedge clk);
         bus_if.err_clear = 1'b0;
         check("acc_err_cleared", 32'(bus_if.bus_error), 32'd0);
      end else begin
         check("acc_no_error", 32'(bus_if.bus_error), 32'd0);
      end
   endtask

   initial begin
      int   cnt;
      logic seen;

      reset                = 1'b1;
      bus_if.cpu_mem_valid = 1'b0;
      bus_if.cpu_mem_addr  = '0;
      bus_if.bus_ready     = 1'b0;
      bus_if.bus_rdata     = '0;
      bus_if.err_clear     = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(bus_if.cpu_mem_ready), 32'd0);
      check("rst_rdata", bus_if.cpu_mem_rdata, 32'd0);
      check("rst_enables", 32'({bus_if.mem_enable, bus_if.io_enable}), 32'd0);
      check("rst_bus_error", 32'(bus_if.bus_error), 32'd0);
      check("rst_err_addr", bus_if.err_addr, 32'd0);
      reset = 1'b0;

      // Basic read, unmapped, and region boundaries.
      access(32'h0000_0010, K_RAM, 32'h1234_5678);
      access(32'h8000_0000, K_UNM, 32'h0);
      access(32'h0000_7FFC, K_RAM, 32'hA5A5_0001);
      access(32'h0000_8000, K_UNM, 32'h0);
      access(32'hFFFF_0000, K_IO,  32'h5A5A_0002);
      access(32'hFFFF_0FFC, K_IO,  32'h0BAD_F00D);
      access(32'hFFFF_1000, K_UNM, 32'h0);

      // Timeout on a silent IO slave.
      @(negedge clk);
      bus_if.cpu_mem_valid = 1'b1;
      bus_if.cpu_mem_addr  = 32'hFFFF_0004;
      sb_q.push_back(ERR_WORD);
      cnt  = 0;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         #1;
         if (bus_if.io_enable) cnt++;
         if (bus_if.cpu_mem_ready) seen = 1'b1;
      end
      check("to_ready_seen", 32'(seen), 32'd1);
      check("to_io_cycles", 32'(cnt), 32'd16);
      check("to_bus_error", 32'(bus_if.bus_error), 32'd1);
      check("to_err_addr", bus_if.err_addr, 32'hFFFF_0004);
      @(negedge clk);
      bus_if.cpu_mem_valid = 1'b0;
      check("to_drained", 32'(sb_q.size()), 32'd0);
      bus_if.err_clear = 1'b1;
      @(negedge clk);
      bus_if.err_clear = 1'b0;

      // Ready arriving in the 16th ACTIVE cycle beats the timeout.
      @(negedge clk);
      bus_if.cpu_mem_valid = 1'b1;
      bus_if.cpu_mem_addr  = 32'hFFFF_0008;
      sb_q.push_back(32'hCAFE_0004);
      repeat (15) @(negedge clk);
      @(negedge clk);
      check("last_io_en", 32'(bus_if.io_enable), 32'd1);
      bus_if.bus_ready = 1'b1;
      bus_if.bus_rdata = 32'hCAFE_0004;
      @(negedge clk);
      bus_if.bus_ready     = 1'b0;
      bus_if.bus_rdata     = '0;
      bus_if.cpu_mem_valid = 1'b0;
      check("last_drained", 32'(sb_q.size()), 32'd0);
      check("last_no_error", 32'(bus_if.bus_error), 32'd0);

      // Abort three cycles into ACTIVE: no response, no error.
      @(negedge clk);
      bus_if.cpu_mem_valid = 1'b1;
      bus_if.cpu_mem_addr  = 32'h0000_0100;
      repeat (3) @(negedge clk);
      check("abort_mem_en_live", 32'(bus_if.mem_enable), 32'd1);
      bus_if.cpu_mem_valid = 1'b0;
      @(negedge clk);
      check("abort_mem_en", 32'(bus_if.mem_enable), 32'd0);
      check("abort_no_error", 32'(bus_if.bus_error), 32'd0);
      access(32'h0000_0200, K_RAM, 32'h7777_0003);

      // Leave an error pending, then reset in the middle of an IO access.
      @(negedge clk);
      bus_if.cpu_mem_valid = 1'b1;
      bus_if.cpu_mem_addr  = 32'hA000_0000;
      sb_q.push_back(ERR_WORD);
      @(negedge clk);
      @(negedge clk);
      bus_if.cpu_mem_valid = 1'b0;
      check("pre_rst_bus_error", 32'(bus_if.bus_error), 32'd1);
      @(negedge clk);
      bus_if.cpu_mem_valid = 1'b1;
      bus_if.cpu_mem_addr  = 32'hFFFF_0010;
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_io_en", 32'(bus_if.io_enable), 32'd1);
      reset                = 1'b1;
      bus_if.cpu_mem_valid = 1'b0;
      @(negedge clk);
      check("mid_rst_io_en", 32'(bus_if.io_enable), 32'd0);
      check("mid_rst_ready", 32'(bus_if.cpu_mem_ready), 32'd0);
      check("mid_rst_rdata", bus_if.cpu_mem_rdata, 32'd0);
      check("mid_rst_bus_error", 32'(bus_if.bus_error), 32'd0);
      check("mid_rst_err_addr", bus_if.err_addr, 32'd0);

      // err_clear and a new error on the same edge: set wins.
      reset                = 1'b0;
      bus_if.cpu_mem_valid = 1'b1;
      bus_if.cpu_mem_addr  = 32'h9000_0000;
      bus_if.err_clear     = 1'b1;
      sb_q.push_back(ERR_WORD);
      @(negedge clk);
      bus_if.err_clear = 1'b0;
      check("clash_bus_error", 32'(bus_if.bus_error), 32'd1);
      check("clash_err_addr", bus_if.err_addr, 32'h9000_0000);
      @(negedge clk);
      bus_if.cpu_mem_valid = 1'b0;
      check("clash_drained", 32'(sb_q.size()), 32'd0);
      @(negedge clk);
      check("clash_sticky", 32'(bus_if.bus_error), 32'd1);

      repeat (2) @(negedge clk);
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
